// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control unit: sequences IF/ID/EX/MEM/WB over a handshaked memory,
// traps illegal opcodes and memory timeouts, and keeps cycle/retire counters.
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             bcond,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             is_ecall,
    output logic             is_halted,
    output logic [1:0]       error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StIf, StId, StMemAddr, StMemRd, StWbMem, StMemWr, StExR, StExI,
        StWbAlu, StBr, StJal, StJalrEx, StJalrWb, StEcall, StHalted, StError
    } state_e;

    localparam logic [6:0] OpLoad     = 7'b0000011;
    localparam logic [6:0] OpStore    = 7'b0100011;
    localparam logic [6:0] OpArith    = 7'b0110011;
    localparam logic [6:0] OpArithImm = 7'b0010011;
    localparam logic [6:0] OpBranch   = 7'b1100011;
    localparam logic [6:0] OpJal      = 7'b1101111;
    localparam logic [6:0] OpJalr     = 7'b1100111;
    localparam logic [6:0] OpEcall    = 7'b1110011;

    // Wait counter only needs to reach MEM_TIMEOUT-1; the next low cycle trips the trap.
    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [1:0]       error_q, error_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] cycle_q, instr_q;
    logic             retire, waiting, timeout_hit;

    // bcond is consumed by the datapath together with pc_write_cond.
    logic unused_bcond;
    assign unused_bcond = bcond;

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        retire  = 1'b0;
        waiting = 1'b0;
        case (state_q)
            StIf: begin
                waiting = 1'b1;
                if (mem_ready) state_d = StId;
            end
            StId: begin
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAddr;
                    OpArith:         state_d = StExR;
                    OpArithImm:      state_d = StExI;
                    OpBranch:        state_d = StBr;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalrEx;
                    OpEcall:         state_d = StEcall;
                    default: begin
                        state_d = StError;
                        error_d = 2'b10;
                    end
                endcase
            end
            StMemAddr: state_d = (opcode == OpStore) ? StMemWr : StMemRd;
            StMemRd: begin
                waiting = 1'b1;
                if (mem_ready) state_d = StWbMem;
            end
            StMemWr: begin
                waiting = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StIf;
                end
            end
            StExR, StExI: state_d = StWbAlu;
            StJalrEx:     state_d = StJalrWb;
            StWbMem, StWbAlu, StBr, StJal, StJalrWb: begin
                retire  = 1'b1;
                state_d = StIf;
            end
            StEcall: begin
                retire  = 1'b1;
                state_d = halt_req ? StHalted : StIf;
            end
            StHalted, StError: state_d = state_q;
            default: state_d = StIf;
        endcase

        // A ready on the final allowed cycle still completes the access.
        timeout_hit = waiting && (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WaitLast);
        if (timeout_hit) begin
            state_d = StError;
            error_d = 2'b01;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting && !mem_ready) begin
            wait_d = wait_q + WaitW'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIf;
            error_q <= 2'b00;
            wait_q  <= '0;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            wait_q  <= wait_d;
            if (state_q != StHalted && state_q != StError) cycle_q <= cycle_q + CNT_W'(1);
            if (retire) instr_q <= instr_q + CNT_W'(1);
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        wb_sel        = 2'b00;
        is_ecall      = 1'b0;
        if (!reset) begin
            case (state_q)
                StIf: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StId: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                end
                StMemAddr, StJalrEx: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                StWbMem: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'b01;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                StExR: begin
                    alu_src_a = 2'b01;
                    alu_op    = 2'b10;
                end
                StExI: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b10;
                end
                StWbAlu: reg_write = 1'b1;
                StBr: begin
                    alu_src_a     = 2'b01;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                StJal: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b01;
                    reg_write = 1'b1;
                    wb_sel    = 2'b10;
                end
                StJalrWb: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    reg_write = 1'b1;
                    wb_sel    = 2'b10;
                end
                StEcall: is_ecall = 1'b1;
                default: ;
            endcase
        end
    end

    assign is_halted   = !reset && (state_q == StHalted);
    assign error       = reset ? 2'b00 : error_q;
    assign cycle_count = reset ? '0 : cycle_q;
    assign instr_count = reset ? '0 : instr_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: walks every instruction class cycle by cycle
// against hand-written control words, plus timeout, illegal-opcode, halt and reset cases.
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'b0;
    logic        mem_ready = 1'b0;
    logic        bcond = 1'b0;
    logic        halt_req = 1'b0;
    logic        pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, i_or_d;
    logic [1:0]  pc_source, alu_src_a, alu_src_b, alu_op, wb_sel, error;
    logic        is_ecall, is_halted;
    logic [31:0] cycle_count, instr_count;
    logic [20:0] ctrl;

    int n_vec  = 0;
    int n_fail = 0;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .bcond(bcond),
        .halt_req(halt_req), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_sel(wb_sel),
        .is_ecall(is_ecall), .is_halted(is_halted), .error(error),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {pc_write pc_write_cond ir_write reg_write mem_read mem_write i_or_d}
    // _pc_source_alu_src_a_alu_src_b_alu_op_wb_sel_{is_ecall is_halted}_error
    assign ctrl = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, i_or_d,
                   pc_source, alu_src_a, alu_src_b, alu_op, wb_sel, is_ecall, is_halted, error};

    localparam logic [20:0] CIfRdy  = 21'b1010100_00_00_01_00_00_00_00;
    localparam logic [20:0] CIfWait = 21'b0000100_00_00_01_00_00_00_00;
    localparam logic [20:0] CId     = 21'b0000000_00_10_10_00_00_00_00;
    localparam logic [20:0] CAddr   = 21'b0000000_00_01_10_00_00_00_00;
    localparam logic [20:0] CMemRd  = 21'b0000101_00_00_00_00_00_00_00;
    localparam logic [20:0] CWbMem  = 21'b0001000_00_00_00_00_01_00_00;
    localparam logic [20:0] CMemWr  = 21'b0000011_00_00_00_00_00_00_00;
    localparam logic [20:0] CExR    = 21'b0000000_00_01_00_10_00_00_00;
    localparam logic [20:0] CExI    = 21'b0000000_00_01_10_10_00_00_00;
    localparam logic [20:0] CWbAlu  = 21'b0001000_00_00_00_00_00_00_00;
    localparam logic [20:0] CBr     = 21'b0100000_01_01_00_01_00_00_00;
    localparam logic [20:0] CJal    = 21'b1001000_01_00_00_00_10_00_00;
    localparam logic [20:0] CJalrWb = 21'b1001000_10_00_00_00_10_00_00;
    localparam logic [20:0] CEcall  = 21'b0000000_00_00_00_00_00_10_00;
    localparam logic [20:0] CHalted = 21'b0000000_00_00_00_00_00_01_00;
    localparam logic [20:0] CErrTo  = 21'b0000000_00_00_00_00_00_00_01;
    localparam logic [20:0] CErrIll = 21'b0000000_00_00_00_00_00_00_10;
    localparam logic [20:0] CZero   = 21'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive mem_ready, check control word mid-cycle, advance past the edge.
    task automatic cyc(input string tag, input logic rdy, input logic [20:0] exp);
        mem_ready = rdy;
        @(negedge clk);
        check_eq(tag, {43'b0, ctrl}, {43'b0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int cyc_exp, input int ins_exp);
        check_eq({tag, "_cyc"}, {32'b0, cycle_count}, cyc_exp);
        check_eq({tag, "_ins"}, {32'b0, instr_count}, ins_exp);
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        mem_ready = 1'b0;
        halt_req  = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ctrl"}, {43'b0, ctrl}, {43'b0, CZero});
        check_eq({tag, "_cyc"}, {32'b0, cycle_count}, 64'd0);
        check_eq({tag, "_ins"}, {32'b0, instr_count}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset("rst0");

        opcode = 7'b0110011;
        cyc("add_if", 1'b1, CIfRdy);
        cyc("add_id", 1'b1, CId);
        cyc("add_ex", 1'b1, CExR);
        cyc("add_wb", 1'b1, CWbAlu);
        chk_cnt("add", 4, 1);

        // LOAD with three wait cycles; the ready lands on the last cycle before timeout.
        opcode = 7'b0000011;
        cyc("ld_if", 1'b1, CIfRdy);
        cyc("ld_id", 1'b1, CId);
        cyc("ld_addr", 1'b1, CAddr);
        cyc("ld_rd0", 1'b0, CMemRd);
        cyc("ld_rd1", 1'b0, CMemRd);
        cyc("ld_rd2", 1'b0, CMemRd);
        cyc("ld_rd3", 1'b1, CMemRd);
        cyc("ld_wb", 1'b1, CWbMem);
        chk_cnt("ld", 12, 2);

        opcode = 7'b0100011;
        cyc("st_if", 1'b1, CIfRdy);
        cyc("st_id", 1'b1, CId);
        cyc("st_addr", 1'b1, CAddr);
        cyc("st_wr", 1'b1, CMemWr);
        chk_cnt("st", 16, 3);

        opcode = 7'b0010011;
        cyc("addi_if", 1'b1, CIfRdy);
        cyc("addi_id", 1'b1, CId);
        cyc("addi_ex", 1'b1, CExI);
        cyc("addi_wb", 1'b1, CWbAlu);
        chk_cnt("addi", 20, 4);

        opcode = 7'b1100011;
        cyc("br_if", 1'b1, CIfRdy);
        cyc("br_id", 1'b1, CId);
        cyc("br_br", 1'b1, CBr);
        chk_cnt("br", 23, 5);

        opcode = 7'b1101111;
        cyc("jal_if", 1'b1, CIfRdy);
        cyc("jal_id", 1'b1, CId);
        cyc("jal_jal", 1'b1, CJal);
        chk_cnt("jal", 26, 6);

        opcode = 7'b1100111;
        cyc("jalr_if", 1'b1, CIfRdy);
        cyc("jalr_id", 1'b1, CId);
        cyc("jalr_ex", 1'b1, CAddr);
        cyc("jalr_wb", 1'b1, CJalrWb);
        chk_cnt("jalr", 30, 7);

        // ECALL without halt, with two fetch wait cycles.
        opcode   = 7'b1110011;
        halt_req = 1'b0;
        cyc("ec0_if0", 1'b0, CIfWait);
        cyc("ec0_if1", 1'b0, CIfWait);
        cyc("ec0_if2", 1'b1, CIfRdy);
        cyc("ec0_id", 1'b1, CId);
        cyc("ec0_ec", 1'b1, CEcall);
        chk_cnt("ec0", 35, 8);

        halt_req = 1'b1;
        cyc("ec1_if", 1'b1, CIfRdy);
        cyc("ec1_id", 1'b1, CId);
        cyc("ec1_ec", 1'b1, CEcall);
        halt_req = 1'b0;
        cyc("halt0", 1'b1, CHalted);
        cyc("halt1", 1'b1, CHalted);
        chk_cnt("halt", 38, 9);

        do_reset("rst1");
        opcode = 7'b1111111;
        cyc("ill_if", 1'b1, CIfRdy);
        cyc("ill_id", 1'b1, CId);
        cyc("ill_err0", 1'b1, CErrIll);
        cyc("ill_err1", 1'b1, CErrIll);
        chk_cnt("ill", 2, 0);

        do_reset("rst2");
        opcode = 7'b0110011;
        cyc("to_if0", 1'b0, CIfWait);
        cyc("to_if1", 1'b0, CIfWait);
        cyc("to_if2", 1'b0, CIfWait);
        cyc("to_if3", 1'b0, CIfWait);
        cyc("to_err0", 1'b1, CErrTo);
        cyc("to_err1", 1'b0, CErrTo);
        chk_cnt("to", 4, 0);
        do_reset("rst3");
        cyc("post_to_if", 1'b0, CIfWait);

        // Reset in the middle of a stalled store.
        do_reset("rst4");
        opcode = 7'b0100011;
        cyc("sw_if", 1'b1, CIfRdy);
        cyc("sw_id", 1'b1, CId);
        cyc("sw_addr", 1'b1, CAddr);
        cyc("sw_wr0", 1'b0, CMemWr);
        cyc("sw_wr1", 1'b0, CMemWr);
        do_reset("rst_mid");
        cyc("sw_post_if0", 1'b0, CIfWait);
        cyc("sw_post_if1", 1'b1, CIfRdy);
        chk_cnt("sw_post", 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Parametrised multicycle control unit for the RV32I core. It sequences fetch, decode, execute, memory and write-back over a variable-latency memory with a `mem_ready` handshake, instead of assuming single-cycle memory. It also implements correct JAL/JALR link write-back, ECALL halt, illegal-opcode and memory-timeout error trapping, and cycle/retired-instruction counters. It drives the same datapath mux and enable controls as the current control unit, with widened PC-source, ALU-A and write-back selects.

## Interface
- `MEM_TIMEOUT`, default 16: max consecutive `mem_ready`-low cycles per access; 0 disables the timeout.
- `CNT_W`, default 32: width of the performance counters.
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  7  IR[6:0]; valid from ID onward.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `bcond`  in  1  branch-taken result from the ALU compare.
- `halt_req`  in  1  datapath flag (x17==10); sampled only in ECALL.
- `pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_read`, `mem_write`, `i_or_d`  out  1 each  datapath enables/selects.
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 ALUOut & ~1.
- `alu_src_a`  out  2  00 PC, 01 A (rs1), 10 old_pc (latched by the datapath on `ir_write`).
- `alu_src_b`  out  2  00 B (rs2), 01 constant 4, 10 immediate.
- `alu_op`  out  2  00 add, 01 branch compare, 10 funct decode.
- `wb_sel`  out  2  00 ALUOut, 01 MDR, 10 PC.
- `is_ecall`  out  1  high during the ECALL state.
- `is_halted`  out  1  sticky halt.
- `error`  out  2  sticky: 00 none, 01 memory timeout, 10 illegal opcode.
- `cycle_count`, `instr_count`  out  CNT_W  performance counters.

## Operation
- Opcodes: LOAD 0000011, STORE 0100011, ARITH 0110011, ARITH_IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011.
- Outputs not listed for a state are 0. `reset` high forces every output and both counters to 0; the next state is IF.
- IF: `mem_read`=1, `alu_src_a`=00, `alu_src_b`=01. `ir_write`=`pc_write`=`mem_ready` (combinational). Waits in IF until `mem_ready`, then goes to ID.
- ID: `alu_src_a`=10, `alu_src_b`=10 (ALUOut←old_pc+imm). Next state by opcode: LOAD/STORE→MEM_ADDR; ARITH→EX_R; ARITH_IMM→EX_I; BRANCH→BR; JAL→JAL; JALR→JALR_EX; ECALL→ECALL; any other opcode→ERROR with `error`=10.
- MEM_ADDR: `alu_src_a`=01, `alu_src_b`=10. Goes to MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD: `mem_read`=`i_or_d`=1. Waits for `mem_ready`, then goes to WB_MEM.
- WB_MEM: `reg_write`=1, `wb_sel`=01. Retires; next state IF.
- MEM_WR: `mem_write`=`i_or_d`=1. Waits for `mem_ready`, then retires and goes to IF.
- EX_R: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=10. Next state WB_ALU.
- EX_I: as EX_R but `alu_src_b`=10. Next state WB_ALU.
- WB_ALU: `reg_write`=1, `wb_sel`=00. Retires; next state IF.
- BR: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. The datapath gates the write with `bcond`. Retires; next state IF.
- JAL: `pc_write`=1, `pc_source`=01, `reg_write`=1, `wb_sel`=10. The PC still holds old_pc+4, so rd gets the link address. Retires; next state IF.
- JALR_EX: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00. Next state JALR_WB.
- JALR_WB: `pc_write`=1, `pc_source`=10, `reg_write`=1, `wb_sel`=10. Retires; next state IF.
- ECALL: `is_ecall`=1. Retires. Goes to HALTED if `halt_req`=1, otherwise IF.
- HALTED and ERROR: all controls 0. Both are sticky; only `reset` exits them.
- Timeout: a wait counter clears on entering IF, MEM_RD or MEM_WR. It counts each cycle with `mem_ready`=0. Ready on the cycle that would reach `MEM_TIMEOUT` wins. After `MEM_TIMEOUT` consecutive low cycles: go to ERROR, `error`=01, `mem_read`/`mem_write` drop.
- Counters: `cycle_count` +1 every non-reset cycle while not in HALTED/ERROR. `instr_count` +1 on each retire cycle. Both wrap modulo 2^CNT_W.

## Timing
- Moore outputs, except `ir_write`/`pc_write` in IF, which follow `mem_ready` combinationally.
- Zero-wait latencies (cycles, IF to retire inclusive): ARITH/ARITH_IMM 4, LOAD 5, STORE 4, BRANCH 3, JAL 3, JALR 4, ECALL 3. Each wait cycle adds 1.
- First IF is the cycle after `reset` deasserts. A reset asserted mid-instruction aborts it with no retire counted.
- `mem_read`/`mem_write` stay stable until the `mem_ready` cycle; they deassert the cycle after.

## Test plan
- ADD with `mem_ready` tied 1 → states IF,ID,EX_R,WB_ALU; `reg_write` in cycle 4; `instr_count`=1, `cycle_count`=4.
- LOAD with 3 wait cycles in MEM_RD → 8 cycles total; `mem_read`=`i_or_d`=1 held for 4 cycles; WB_MEM `wb_sel`=01.
- JAL then JALR → JAL: `pc_source`=01, `wb_sel`=10 in cycle 3; JALR_WB: `pc_source`=10 in cycle 4.
- `MEM_TIMEOUT`=4, `mem_ready`=0 in IF → `error`=01 after 4 cycles, `mem_read` drops, counters freeze; `reset` → IF, `error`=00.
- Opcode 1111111 → ERROR from ID, `error`=10, no retire. ECALL with `halt_req`=1 → `is_ecall` for 1 cycle, then `is_halted`=1 sticky.
- Reset during MEM_WR wait → next state IF, all outputs 0 during reset, counters 0, no `mem_write` after reset.
